// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and baud timing helpers.
// Imported by uart_rx and intended for reuse by a matching transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   function automatic int unsigned bit_ticks(input int unsigned clk_rate,
                                             input int unsigned baud_rate);
      return clk_rate / baud_rate;
   endfunction

   function automatic int unsigned half_ticks(input int unsigned clk_rate,
                                              input int unsigned baud_rate);
      return bit_ticks(clk_rate, baud_rate) / 32'd2;
   endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous line.
// Both stages preset to 1 so an idle-high line never looks like a falling edge out of reset.
module uart_sync (
   input  logic clock,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic meta_d;
   logic sync_q;
   logic sync_d;

   // Next-state of the two synchronizer stages.
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // Synchronizer stage registers.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, WORD_WIDTH data bits LSB first, one parity bit, one stop bit.
// Samples mid-bit from a start edge; word and error flags are loaded together with a one-cycle valid pulse.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned BAUD_RATE   = 115200,
   parameter int unsigned CLK_RATE    = 100000000,
   parameter int unsigned WORD_WIDTH  = 8,
   parameter int unsigned EVEN_PARITY = 0
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic                  rx_data_in,
   output logic [WORD_WIDTH-1:0] rx_data_out,
   output logic                  rx_data_valid,
   output logic                  rx_parity_err,
   output logic                  rx_frame_err,
   output logic                  rx_busy
);

   localparam int unsigned BIT_TICKS  = bit_ticks(CLK_RATE, BAUD_RATE);
   localparam int unsigned HALF_TICKS = half_ticks(CLK_RATE, BAUD_RATE);
   localparam int          CNT_W      = (BIT_TICKS > 32'd1) ? $clog2(BIT_TICKS) : 1;
   localparam int          BITC_W     = $clog2(WORD_WIDTH + 32'd1);

   localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0]      BIT_LAST  = CNT_W'(BIT_TICKS - 32'd1);
   localparam logic [CNT_W-1:0]      HALF_LAST = CNT_W'(HALF_TICKS - 32'd1);
   localparam logic [BITC_W-1:0]     BITC_ZERO = {BITC_W{1'b0}};
   localparam logic [BITC_W-1:0]     BITC_ONE  = BITC_W'(1'b1);
   localparam logic [BITC_W-1:0]     WORD_LAST = BITC_W'(WORD_WIDTH - 32'd1);
   localparam logic [WORD_WIDTH-1:0] WORD_ZERO = {WORD_WIDTH{1'b0}};

   function automatic logic expected_parity(input logic [WORD_WIDTH-1:0] data);
      logic p;
      p = ^data;
      if (EVEN_PARITY != 32'd0) begin
         return p;
      end else begin
         return ~p;
      end
   endfunction

   logic line_s;
   logic fall_s;

   uart_state_e             state_q,    state_d;
   logic [CNT_W-1:0]        cnt_q,      cnt_d;
   logic [BITC_W-1:0]       bit_cnt_q,  bit_cnt_d;
   logic [WORD_WIDTH-1:0]   shift_q,    shift_d;
   logic                    par_flag_q, par_flag_d;
   logic                    prev_q,     prev_d;
   logic [WORD_WIDTH-1:0]   data_out_q, data_out_d;
   logic                    valid_q,    valid_d;
   logic                    par_err_q,  par_err_d;
   logic                    frm_err_q,  frm_err_d;
   logic                    busy_q,     busy_d;

   uart_sync u_sync (
      .clock (clock),
      .rst   (rst),
      .d     (rx_data_in),
      .q     (line_s)
   );

   // Only a true 1->0 transition starts a frame; a line that stays low never retriggers.
   assign fall_s = prev_q & ~line_s;

   // Next-state, counters, shift register and output loads.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_flag_d = par_flag_q;
      prev_d     = line_s;
      data_out_d = data_out_q;
      valid_d    = 1'b0;
      par_err_d  = par_err_q;
      frm_err_d  = frm_err_q;

      case (state_q)
         ST_IDLE: begin
            cnt_d = CNT_ZERO;
            if (fall_s) begin
               state_d = ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d     = CNT_ZERO;
               bit_cnt_d = BITC_ZERO;
               if (!line_s) begin
                  state_d = ST_DATA;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d               = CNT_ZERO;
               shift_d             = shift_q >> 1;
               shift_d[WORD_WIDTH-1] = line_s;
               if (bit_cnt_q == WORD_LAST) begin
                  bit_cnt_d = BITC_ZERO;
                  state_d   = ST_PARITY;
               end else begin
                  bit_cnt_d = bit_cnt_q + BITC_ONE;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_PARITY: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d      = CNT_ZERO;
               par_flag_d = (line_s != expected_parity(shift_q));
               state_d    = ST_STOP;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d      = CNT_ZERO;
               data_out_d = shift_q;
               par_err_d  = par_flag_q;
               frm_err_d  = ~line_s;
               valid_d    = 1'b1;
               state_d    = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and datapath registers.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= CNT_ZERO;
         bit_cnt_q  <= BITC_ZERO;
         shift_q    <= WORD_ZERO;
         par_flag_q <= 1'b0;
         prev_q     <= 1'b1;
         data_out_q <= WORD_ZERO;
         valid_q    <= 1'b0;
         par_err_q  <= 1'b0;
         frm_err_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_flag_q <= par_flag_d;
         prev_q     <= prev_d;
         data_out_q <= data_out_d;
         valid_q    <= valid_d;
         par_err_q  <= par_err_d;
         frm_err_q  <= frm_err_d;
         busy_q     <= busy_d;
      end
   end

   assign rx_data_out   = data_out_q;
   assign rx_data_valid = valid_q;
   assign rx_parity_err = par_err_q;
   assign rx_frame_err  = frm_err_q;
   assign rx_busy       = busy_q;

endmodule
